// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared definitions for the pipeline control blocks:
//             forwarding-select codes, hazard FSM state encoding and the
//             default register-index width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

  // Default register-index width (32 architectural registers)
  localparam int REG_AW_DEF = 5;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // value being written back
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result held in EX/MEM

  // Hazard controller states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
//  Module   : forward_unit
//  Purpose  : Combinational EX-stage operand forwarding selects. A producer
//             in MEM takes priority over one in WB; register 0 never forwards.
//  Ports    : ex_rs1 / ex_rs2            EX operand source registers
//             mem_rd / mem_reg_write     MEM-stage destination and write flag
//             wb_rd  / wb_reg_write      WB-stage destination and write flag
//             fwd_a  / fwd_b             operand A / B source select
//  Revision : 1.0  initial release
// ============================================================================
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  function automatic logic [1:0] sel_src(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    logic [1:0] s;
    s = FWD_RF;
    if (m_we && (m_rd != '0) && (m_rd == rs)) begin
      s = FWD_MEM;
    end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
      s = FWD_WB;
    end
    return s;
  endfunction

  always_comb begin
    fwd_a = sel_src(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b = sel_src(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  end

endmodule : forward_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard controller. Generates enable/flush strobes for
//             the PC, IF/ID, ID/EX and EX/MEM registers (load-use stall,
//             taken-branch flush penalty, freeze on data-memory busy) and the
//             EX-stage forwarding selects.
//  Ports    : clk, reset (async, active high)
//             id_rs1, id_rs2, ex_rd, ex_mem_read      load-use detection
//             ex_rs1, ex_rs2, mem_rd, mem_reg_write,
//             wb_rd, wb_reg_write                     forwarding
//             branch_taken, dmem_busy                 control events
//             pc_write, if_id_write, id_ex_write,
//             ex_mem_write                            register enables
//             if_id_flush, id_ex_flush                NOP / bubble insert
//             fwd_a, fwd_b                            operand selects
//             stall_cycles, flush_cycles              (HAZARD_PERF_CNT_EN)
//  Config   : HAZARD_PERF_CNT_EN adds saturating 32-bit counters of cycles
//             with pc_write low and cycles with if_id_flush high.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW         = REG_AW_DEF,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              branch_taken,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  localparam logic [2:0] PEN_M1 = 3'(BRANCH_PENALTY - 1);

  hz_state_t  r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_br_pend, w_br_pend_nxt;
  logic       r_from_flush, w_from_flush_nxt;

  logic       w_lu;
  logic       w_br_any;   // a branch action is due this cycle
  logic       w_fl_ctx;   // we are inside a flush sequence (possibly frozen)
  logic       w_do_br, w_do_fl, w_do_lu;
  logic [1:0] w_fwd_a, w_fwd_b;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_cnt        <= 3'd0;
      r_br_pend    <= 1'b0;
      r_from_flush <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_br_pend    <= w_br_pend_nxt;
      r_from_flush <= w_from_flush_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and strobes. Priority: dmem_busy > branch > flush step > lu.
  // The MEM_WAIT exit cycle replays whatever the frozen cycle would have done:
  // a deferred branch, the interrupted flush step, or normal RUN evaluation.
  // --------------------------------------------------------------------------
  always_comb begin
    w_lu     = ex_mem_read && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    w_br_any = branch_taken || ((r_state == MEM_WAIT) && r_br_pend);
    w_fl_ctx = (r_state == FLUSH) || ((r_state == MEM_WAIT) && r_from_flush);
    w_do_br  = !dmem_busy && w_br_any;
    w_do_fl  = !dmem_busy && !w_br_any && w_fl_ctx;
    w_do_lu  = !dmem_busy && !w_br_any && !w_fl_ctx && w_lu;

    w_state_nxt      = RUN;
    w_cnt_nxt        = r_cnt;
    w_br_pend_nxt    = 1'b0;
    w_from_flush_nxt = 1'b0;
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    id_ex_write      = 1'b1;
    ex_mem_write     = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;

    if (dmem_busy) begin
      pc_write         = 1'b0;
      if_id_write      = 1'b0;
      id_ex_write      = 1'b0;
      ex_mem_write     = 1'b0;
      w_state_nxt      = MEM_WAIT;
      w_br_pend_nxt    = w_br_any;
      w_from_flush_nxt = w_fl_ctx;
    end else if (w_do_br) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_cnt_nxt   = PEN_M1;
      w_state_nxt = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
    end else if (w_do_fl) begin
      if_id_flush = 1'b1;
      if (r_cnt <= 3'd1) begin
        w_cnt_nxt   = 3'd0;
        w_state_nxt = RUN;
      end else begin
        w_cnt_nxt   = r_cnt - 3'd1;
        w_state_nxt = FLUSH;
      end
    end else if (w_do_lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end

    // Reset dominates the strobes combinationally, not just after an edge
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  forward_unit #(
    .REG_AW (REG_AW)
  ) u_fwd (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (w_fwd_a),
    .fwd_b         (w_fwd_b)
  );

  assign fwd_a = reset ? FWD_RF : w_fwd_a;
  assign fwd_b = reset ? FWD_RF : w_fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_cycles <= 32'd0;
    end else begin
      if (!pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (if_id_flush && (r_flush_cycles != 32'hFFFF_FFFF)) begin
        r_flush_cycles <= r_flush_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
`endif

endmodule : hazard_ctrl
`default_nettype wire
